// File: rtl/jk_decade_if.sv
// Signal bundle for the JK decade counter: reset/set qualifiers, /5 enable and the Q outputs.
// The TC output exists only when JK_DECADE_TC_EN is defined.
interface jk_decade_if;
  logic R01;
  logic R02;
  logic R91;
  logic R92;
  logic inputB;
  logic QA;
  logic QB;
  logic QC;
  logic QD;
`ifdef JK_DECADE_TC_EN
  logic TC;

  modport master (
    output R01, R02, R91, R92, inputB,
    input  QA, QB, QC, QD, TC
  );

  modport slave (
    input  R01, R02, R91, R92, inputB,
    output QA, QB, QC, QD, TC
  );
`else
  modport master (
    output R01, R02, R91, R92, inputB,
    input  QA, QB, QC, QD
  );

  modport slave (
    input  R01, R02, R91, R92, inputB,
    output QA, QB, QC, QD
  );
`endif
endinterface

// File: rtl/jk_decade_counter.sv
// 7490-style decade counter: QA is a /2 JK stage, QB..QD a /5 JK stage enabled by inputB,
// all clocked by inputA. Optional terminal-count output TC under JK_DECADE_TC_EN.
module jk_decade_counter #(
  parameter bit ACTIVE_FALLING = 1'b1
) (
  input logic       inputA,
  jk_decade_if.slave bus
);

  logic qa, qb, qc, qd;
  logic qa_nxt, qb_nxt, qc_nxt, qd_nxt;
  logic r0, r9;

  function automatic logic jk(input logic q, input logic j, input logic k);
    return (j & ~q) | (~k & q);
  endfunction

  assign r0 = bus.R01 & bus.R02;
  assign r9 = bus.R91 & bus.R92;

  always_comb begin
    qa_nxt = jk(qa, 1'b1, 1'b1);
    qb_nxt = qb;
    qc_nxt = qc;
    qd_nxt = qd;
    if (bus.inputB) begin
      // The plain 7490 equations send 101 to 010; force every illegal state to 000 instead.
      if (qd & (qc | qb)) begin
        qb_nxt = 1'b0;
        qc_nxt = 1'b0;
        qd_nxt = 1'b0;
      end else begin
        qb_nxt = jk(qb, ~qd, 1'b1);
        qc_nxt = jk(qc, qb, qb);
        qd_nxt = jk(qd, qb & qc, 1'b1);
      end
    end
  end

  generate
    if (ACTIVE_FALLING) begin : g_fall
      always_ff @(negedge inputA) begin
        if (r9) begin
          {qd, qc, qb, qa} <= 4'b1001;
        end else if (r0) begin
          {qd, qc, qb, qa} <= 4'b0000;
        end else begin
          {qd, qc, qb, qa} <= {qd_nxt, qc_nxt, qb_nxt, qa_nxt};
        end
      end
    end else begin : g_rise
      always_ff @(posedge inputA) begin
        if (r9) begin
          {qd, qc, qb, qa} <= 4'b1001;
        end else if (r0) begin
          {qd, qc, qb, qa} <= 4'b0000;
        end else begin
          {qd, qc, qb, qa} <= {qd_nxt, qc_nxt, qb_nxt, qa_nxt};
        end
      end
    end
  endgenerate

  assign bus.QA = qa;
  assign bus.QB = qb;
  assign bus.QC = qc;
  assign bus.QD = qd;

`ifdef JK_DECADE_TC_EN
  assign bus.TC = qd & qa & ~qc & ~qb;
`endif

endmodule

// File: tb/tb_jk_decade_counter.sv
// Directed-vector scoreboard bench for jk_decade_counter (falling-edge build, period 10).
module tb_jk_decade_counter;

  typedef struct {
    string      name;
    logic [3:0] q;
  } exp_t;

  logic       inputA;
  int         bmode;
  int         vectors;
  int         miscompares;
  exp_t       sb[$];

  jk_decade_if bus();

  jk_decade_counter #(.ACTIVE_FALLING(1'b1)) dut (
    .inputA (inputA),
    .bus    (bus)
  );

  // bmode 0: cascade inputB=QA; 1: inputB tied high; 2: inputB tied low
  assign bus.inputB = (bmode == 0) ? bus.QA : (bmode == 1);

  initial begin
    inputA = 1'b1;
    forever #5 inputA = ~inputA;
  end

  // Monitor: active edge is the falling edge, so outputs are sampled on the rising edge.
  initial begin
    exp_t       e;
    logic [3:0] got;
    forever begin
      @(posedge inputA);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {bus.QD, bus.QC, bus.QB, bus.QA};
        vectors++;
        if (got !== e.q) begin
          miscompares++;
          $display("FAIL %s: Q got %b expected %b", e.name, got, e.q);
        end
`ifdef JK_DECADE_TC_EN
        if (bus.TC !== (e.q == 4'd9)) begin
          miscompares++;
          $display("FAIL %s: TC got %b expected %b", e.name, bus.TC, (e.q == 4'd9));
        end
`endif
      end
    end
  end

  task automatic step(input logic r01, input logic r02, input logic r91, input logic r92,
                      input int mode, input logic [3:0] q, input string name);
    exp_t e;
    @(posedge inputA);
    #1;
    bus.R01 = r01;
    bus.R02 = r02;
    bus.R91 = r91;
    bus.R92 = r92;
    bmode   = mode;
    e.name  = name;
    e.q     = q;
    sb.push_back(e);
  endtask

  initial begin
    logic [3:0] cnt_tbl[10];
    logic [3:0] t5_tbl[9];
    cnt_tbl = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
    // inputB high: QA toggles, QD:QC:QB cycles 1,2,3,4,0,1; then inputB low holds 001
    t5_tbl  = '{4'b0011, 4'b0100, 4'b0111, 4'b1000, 4'b0001, 4'b0010,
                4'b0011, 4'b0010, 4'b0011};
    vectors     = 0;
    miscompares = 0;
    bmode       = 0;
    bus.R01 = 1'b0;
    bus.R02 = 1'b0;
    bus.R91 = 1'b0;
    bus.R92 = 1'b0;

    // Reset then full BCD cycle
    step(1, 1, 0, 0, 0, 4'd0, "t1_reset");
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, cnt_tbl[i], "t1_count");

    // Count to 5, reset mid-count, resume from 0
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, cnt_tbl[i], "t2_count");
    step(1, 1, 0, 0, 0, 4'd0, "t2_r0");
    step(0, 0, 0, 0, 0, 4'd1, "t2_resume");

    // From 1 count to 3, set to 9, wrap to 0 then 1
    step(0, 0, 0, 0, 0, 4'd2, "t3_count");
    step(0, 0, 0, 0, 0, 4'd3, "t3_count");
    step(0, 0, 1, 1, 0, 4'd9, "t3_r9");
    step(0, 0, 0, 0, 0, 4'd0, "t3_wrap");
    step(0, 0, 0, 0, 0, 4'd1, "t3_resume");

    // R9 wins over R0; half-qualified R0 does nothing
    step(1, 1, 1, 1, 0, 4'd9, "t4_r9_prio");
    step(1, 0, 0, 0, 0, 4'd0, "t4_r01_only");
    step(1, 0, 0, 0, 0, 4'd1, "t4_r01_only");
    step(0, 0, 1, 0, 0, 4'd2, "t4_r91_only");

    // /5 stage with inputB tied high, then held with inputB low
    step(1, 1, 0, 0, 1, 4'd0, "t5_reset");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, t5_tbl[i], "t5_en");
    for (int i = 6; i < 9; i++) step(0, 0, 0, 0, 2, t5_tbl[i], "t5_hold");

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge inputA);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d outstanding expected vectors, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
